// File: rtl/psi_sched_pkg.sv
// psi_sched_pkg: shared constants, FSM state type and null-header helper for the PSI slot scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package psi_sched_pkg;

  localparam logic [7:0]  TS_SYNC       = 8'h47;
  localparam logic [12:0] NULL_PID      = 13'h1FFF;
  localparam int          WORDS_PER_PKT = 47;
  localparam logic [5:0]  LAST_WORD     = 6'(WORDS_PER_PKT - 1);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,  // between packets, looking for the next header word
    S_INS  = 2'd1,  // inside a granted null slot
    S_PASS = 2'd2   // inside a packet that is passed through untouched
  } sched_state_t;

  // Header word carries sync byte in [31:24] and the 13-bit PID in [20:8].
  function automatic logic is_null_hdr(input logic [31:0] word);
    return (word[31:24] == TS_SYNC) && (word[20:8] == NULL_PID);
  endfunction

endpackage

// File: rtl/psi_slot_scheduler_if.sv
// psi_slot_scheduler_if: TS stream, timebase, channel config and slot-grant signals of the scheduler.
// Ports: master = stream/config source (ts_din*, tick_1ms, cfg_*), slave = scheduler (ins_*, pending).
// Optional PSI_SCHED_STATS_EN adds stat_clr (master -> slave) and stat_miss (slave -> master).
interface psi_slot_scheduler_if #(
  parameter int NCH = 4,
  parameter int CW  = 2,
  parameter int IW  = 16
);
  logic [31:0]    ts_din;
  logic           ts_din_en;
  logic           tick_1ms;
  logic           cfg_wr;
  logic [CW-1:0]  cfg_chan;
  logic           cfg_enable;
  logic [IW-1:0]  cfg_interval;
  logic           ins_start;
  logic           ins_active;
  logic [CW-1:0]  ins_sel;
  logic           ins_abort;
  logic [NCH-1:0] pending;
`ifdef PSI_SCHED_STATS_EN
  logic             stat_clr;
  logic [NCH*8-1:0] stat_miss;

  modport master (
    output ts_din, ts_din_en, tick_1ms, cfg_wr, cfg_chan, cfg_enable, cfg_interval, stat_clr,
    input  ins_start, ins_active, ins_sel, ins_abort, pending, stat_miss
  );
  modport slave (
    input  ts_din, ts_din_en, tick_1ms, cfg_wr, cfg_chan, cfg_enable, cfg_interval, stat_clr,
    output ins_start, ins_active, ins_sel, ins_abort, pending, stat_miss
  );
`else
  modport master (
    output ts_din, ts_din_en, tick_1ms, cfg_wr, cfg_chan, cfg_enable, cfg_interval,
    input  ins_start, ins_active, ins_sel, ins_abort, pending
  );
  modport slave (
    input  ts_din, ts_din_en, tick_1ms, cfg_wr, cfg_chan, cfg_enable, cfg_interval,
    output ins_start, ins_active, ins_sel, ins_abort, pending
  );
`endif
endinterface

// File: rtl/psi_rr_arbiter.sv
// psi_rr_arbiter: round-robin picker, first set req bit searched upward from ptr+1 with wrap.
// Latency: purely combinational.
// Ports: req[NCH], ptr[CW] in; gnt_idx[CW], gnt_valid out. No backpressure.
module psi_rr_arbiter #(
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  ptr,
  output logic [CW-1:0]  gnt_idx,
  output logic           gnt_valid
);

  // Two descending scans: the lowest requester at or below ptr is the wrap-around
  // fallback; the lowest requester above ptr, if any, overrides it.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i] && (CW'(i) <= ptr)) begin
        gnt_idx   = CW'(i);
        gnt_valid = 1'b1;
      end
    end
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i] && (CW'(i) > ptr)) begin
        gnt_idx   = CW'(i);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/psi_slot_scheduler.sv
// psi_slot_scheduler: per-channel repetition timers; grants each null TS packet slot round-robin to a pending table.
// Latency: ins_start/ins_active rise 1 cycle after the null header word and cover 47 cycles (1-cycle-delayed data).
// Backpressure: none, stream is never stalled; ts_din_en falling mid-slot pulses ins_abort and re-arms the channel.
// Ports: clk, rst (async active-high); bus = psi_slot_scheduler_if.slave (stream, tick, cfg, ins_*, pending).
// Option: define PSI_SCHED_STATS_EN for stat_clr / stat_miss (saturating lost-expiry counters, 8 bit per channel).
module psi_slot_scheduler
  import psi_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 2,
  parameter int IW  = 16
) (
  input logic                clk,
  input logic                rst,
  psi_slot_scheduler_if.slave bus
);

  // ---------------- stream position ----------------
  logic [5:0] wcnt;
  logic       hdr;
  logic       last_word;

  assign hdr       = bus.ts_din_en && (wcnt == 6'd0);
  assign last_word = bus.ts_din_en && (wcnt == LAST_WORD);

  // Wraps after the 47th word so gap-free back-to-back packets still find their headers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 wcnt <= 6'd0;
    else if (!bus.ts_din_en) wcnt <= 6'd0;
    else if (last_word)      wcnt <= 6'd0;
    else                     wcnt <= wcnt + 6'd1;
  end

  // ---------------- state / registered outputs ----------------
  sched_state_t   state;
  logic           ins_start_q;
  logic           ins_active_q;
  logic [CW-1:0]  ins_sel_q;
  logic           ins_abort_q;
  logic [CW-1:0]  rr_ptr;
  logic [NCH-1:0] pend;

  logic [CW-1:0]  gnt_idx;
  logic           gnt_valid;
  logic           grant_take;
  logic           abort_take;

  psi_rr_arbiter #(.NCH(NCH), .CW(CW)) u_arb (
    .req       (pend),
    .ptr       (rr_ptr),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign grant_take = (state == S_WAIT) && hdr && is_null_hdr(bus.ts_din) && gnt_valid;
  assign abort_take = (state == S_INS) && !bus.ts_din_en;

  // ---------------- channel timers ----------------
  logic           chan_en [NCH];
  logic [IW-1:0]  ivl     [NCH];
  logic [IW-1:0]  cnt     [NCH];
  logic [NCH-1:0] cfg_hit;
  logic [NCH-1:0] counting;
  logic [NCH-1:0] expire;

  always_comb begin
    cfg_hit  = '0;
    counting = '0;
    expire   = '0;
    for (int i = 0; i < NCH; i++) begin
      cfg_hit[i]  = bus.cfg_wr && (bus.cfg_chan == CW'(i));
      counting[i] = chan_en[i] && (ivl[i] != '0);
      // A config write to the same channel swallows the tick.
      expire[i]   = counting[i] && !cfg_hit[i] && bus.tick_1ms && (cnt[i] <= IW'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      for (int i = 0; i < NCH; i++) begin
        chan_en[i] <= 1'b0;
        ivl[i]     <= '0;
        cnt[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cfg_hit[i]) begin
          chan_en[i] <= bus.cfg_enable;
          ivl[i]     <= bus.cfg_interval;
          cnt[i]     <= bus.cfg_interval;
          pend[i]    <= 1'b0;
        end else if (!counting[i]) begin
          pend[i] <= 1'b0;
        end else begin
          if (bus.tick_1ms) cnt[i] <= expire[i] ? ivl[i] : cnt[i] - IW'(1);
          // A fresh expiry outranks the grant clearing this channel's flag.
          if (expire[i])                                     pend[i] <= 1'b1;
          else if (grant_take && (gnt_idx == CW'(i)))        pend[i] <= 1'b0;
          else if (abort_take && (ins_sel_q == CW'(i)))      pend[i] <= 1'b1;
        end
      end
    end
  end

  // ---------------- slot FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_WAIT;
      ins_start_q  <= 1'b0;
      ins_active_q <= 1'b0;
      ins_sel_q    <= '0;
      ins_abort_q  <= 1'b0;
      rr_ptr       <= CW'(NCH - 1);
    end else begin
      ins_start_q <= 1'b0;
      ins_abort_q <= 1'b0;
      case (state)
        S_WAIT: begin
          // ins_active is held through the cycle after the last word so it spans
          // the delayed copy of all 47 words; it drops here unless a new slot begins.
          ins_active_q <= 1'b0;
          if (grant_take) begin
            state        <= S_INS;
            ins_start_q  <= 1'b1;
            ins_active_q <= 1'b1;
            ins_sel_q    <= gnt_idx;
            rr_ptr       <= gnt_idx;
          end else if (hdr) begin
            state <= S_PASS;
          end
        end
        S_INS: begin
          if (!bus.ts_din_en) begin
            ins_abort_q  <= 1'b1;
            ins_active_q <= 1'b0;
            state        <= S_WAIT;
          end else if (last_word) begin
            state <= S_WAIT;
          end
        end
        S_PASS: begin
          if (!bus.ts_din_en || last_word) state <= S_WAIT;
        end
        default: state <= S_WAIT;
      endcase
    end
  end

  assign bus.ins_start  = ins_start_q;
  assign bus.ins_active = ins_active_q;
  assign bus.ins_sel    = ins_sel_q;
  assign bus.ins_abort  = ins_abort_q;
  assign bus.pending    = pend;

`ifdef PSI_SCHED_STATS_EN
  // ---------------- lost-expiry statistics ----------------
  logic [7:0]     miss_cnt [NCH];
  logic [NCH-1:0] lost;

  assign lost = expire & pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) miss_cnt[i] <= 8'd0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.stat_clr)                           miss_cnt[i] <= 8'd0;
        else if (lost[i] && (miss_cnt[i] != 8'hFF)) miss_cnt[i] <= miss_cnt[i] + 8'd1;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_stat
    assign bus.stat_miss[g*8 +: 8] = miss_cnt[g];
  end
`endif

endmodule

// File: doc/psi_slot_scheduler.md
Name: psi_slot_scheduler

Overview:
- Sequences periodic table insertion (NIT, SDT, EIT, ...) into the 32-bit TS word stream.
- Keeps a repetition timer and a pending flag for each table channel.
- Watches the stream for null packets (PID 0x1FFF) and grants each null slot to one pending channel, using round-robin.
- Sits ahead of the table-replace blocks. Each replacer substitutes its stored packet only while its grant is active.

Parameters:
- NCH, 4, number of table channels (2..8)
- CW, 2, channel index width, clog2(NCH)
- IW, 16, interval counter width, in tick_1ms units

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- ts_din  in  32  TS word, byte0 in [31:24]
- ts_din_en  in  1  word valid; high for 47 consecutive cycles per 188-byte packet
- tick_1ms  in  1  one-cycle timebase pulse
- cfg_wr  in  1  configuration write strobe
- cfg_chan  in  CW  channel addressed by cfg_wr
- cfg_enable  in  1  channel enable written by cfg_wr
- cfg_interval  in  IW  repetition interval (ms) written by cfg_wr
- ins_start  out  1  one-cycle pulse: granted slot begins
- ins_active  out  1  high for the 47 words of the granted slot
- ins_sel  out  CW  granted channel, stable while ins_active
- ins_abort  out  1  one-cycle pulse: slot truncated
- pending  out  NCH  per-channel pending flags

Behaviour:
- Reset (async): all outputs 0, all channels disabled, interval counters 0, RR pointer = NCH-1, state S_WAIT.

Word counter wcnt (6 bit):
- Clears when ts_din_en=0.
- Increments on each valid word.
- The header word is ts_din_en && wcnt==0.
- Null header: ts_din[31:24]==8'h47 && ts_din[20:8]==13'h1FFF.

Timers:
- cfg_wr loads enable[cfg_chan], interval[cfg_chan] and cnt[cfg_chan]=cfg_interval, and clears pending[cfg_chan].
- Enabled channel with interval≠0: on tick_1ms, cnt decrements. When cnt==1, cnt reloads to interval and pending sets.
- Disabled channel, or interval==0: no counting, pending forced 0.
- cfg_wr and tick on the same channel in the same cycle: cfg_wr wins.

FSM:
- S_WAIT:
  - Null header with |pending → S_INS.
  - Latch the grant: first pending channel searched from RR+1, wrapping.
  - RR ← grant. pending[grant] clears.
  - Any other header → S_PASS.
- S_INS:
  - Leaves after the 47th word (wcnt==46 && ts_din_en) → S_WAIT.
  - ts_din_en falling before word 46 → ins_abort pulse, pending[ins_sel] re-set, → S_WAIT.
- S_PASS: on end of packet (ts_din_en falling or wcnt==46) → S_WAIT.

Output timing and latency:
- All outputs are registered.
- ins_start and ins_active rise in the cycle after the header word, aligned with the downstream one-cycle-delayed data.
- ins_active covers exactly 47 cycles. ins_sel is held until the next grant.

Same-cycle events:
- Expiry and grant clear on the same channel: set wins, so pending stays 1.
- An expiry while pending is already 1 is lost; it is counted under STATS.

Other rules:
- A header arriving while in S_INS is impossible by length and is ignored.
- Reset mid-slot drops ins_active immediately.

Optional Feature:
- Macro: PSI_SCHED_STATS_EN.
- With the macro:
  - Adds output stat_miss [NCH*8-1:0]: per-channel saturating 8-bit count of expiries lost while already pending.
  - Adds input stat_clr, which zeroes all counters.
  - stat_clr has priority over a same-cycle increment.
- Without the macro: no ports and no logic for stats.

Decomposition:
- Package psi_sched_pkg:
  - TS_SYNC=8'h47, NULL_PID=13'h1FFF, WORDS_PER_PKT=47.
  - FSM state encoding S_WAIT/S_INS/S_PASS.
- One sub-module: psi_rr_arbiter.
  - Purely combinational round-robin picker.
  - Inputs: req[NCH], ptr[CW]. Outputs: gnt_idx[CW], gnt_valid.

Test Plan:
- Timer and grant: ch0 enabled, interval=3; three ticks, then a null packet → pending[0]=1 after the 3rd tick; ins_start one cycle after the header; ins_active 47 cycles; ins_sel=0; pending[0]=0.
- Round-robin: ch0, ch1 and ch2 all pending; three consecutive null packets → grants 0,1,2; RR pointer wraps; a fourth null packet with nothing pending gives no ins_start.
- Non-null traffic: PID 0x0011 packets with ch1 pending → no grant; pending[1] stays 1 until the first null packet.
- Truncated slot: ts_din_en drops at word 20 of a granted slot → ins_abort pulse; ins_active falls; pending[sel] re-set; the next null packet re-grants the same channel.
- Configuration priority: cfg_wr to ch2 with enable=0 in the same cycle as an expiry → pending[2]=0; no further counting.
- Stats (PSI_SCHED_STATS_EN): interval=1, 300 ticks with no null packets → stat_miss ch0 saturates at 255; stat_clr → 0.
